// File: rtl/mc_ctrl.sv
// mc_ctrl -- multicycle CPU control unit.
//
// Sequences each instruction through FETCH / DECODE / execute / memory /
// writeback states. It drives the ALU opcode and datapath selects, resolves
// branches from the ALU Zero flag, handshakes with the unified memory through
// mem_rdy, and counts retired instructions.
//
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   Op, Funct         IR[31:26] and IR[5:0], held by the IR from DECODE on
//   Zero              ALU result-equals-zero flag (used in BRANCH only)
//   mem_rdy           memory completes the current access this cycle
//   ALUOp             NOP 000, ADD 001, SUB 010, AND 011, OR 100, SLT 101, SLTU 110
//   ALUSrcA/ALUSrcB   ALU operand selects; ExtOp selects sign/zero extension
//   IorD, MemRead,
//   MemWrite          memory address select and strobes
//   IRWrite, PCWrite,
//   PCSrc             IR / PC enables and PC source select
//   RegWrite, RegDst,
//   MemtoReg          register-file write controls
//   Illegal           one-cycle pulse on an unsupported opcode or funct
//   state             current state code, for debug
//   instret           retired-instruction count, wraps modulo 2^INSTRET_W
module mc_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           Op,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_rdy,
  output logic [2:0]           ALUOp,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 ExtOp,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic [1:0]           PCSrc,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 Illegal,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXEC_I = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  // ALU opcodes
  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  state_e               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire;

  // NOTE: every signal written here gets a default before the case so that no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    retire    = 1'b0;
    ALUOp     = ALU_NOP;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ExtOp     = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 2'b00;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    Illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;          // PC + 4
        ALUOp   = ALU_ADD;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;          // precompute branch target PC + (imm << 2)
        ALUOp   = ALU_ADD;
        case (Op)
          OP_RTYPE: begin
            if (Funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU})
              state_d = S_EXEC_R;
            else begin
              state_d = S_FETCH;
              Illegal = 1'b1;
            end
          end
          OP_LW, OP_SW:           state_d = S_MEMADR;
          OP_ADDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:         state_d = S_BRANCH;
          OP_J:                   state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            Illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        ALUOp   = ALU_ADD;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        case (Funct)
          FN_ADD:  ALUOp = ALU_ADD;
          FN_SUB:  ALUOp = ALU_SUB;
          FN_AND:  ALUOp = ALU_AND;
          FN_OR:   ALUOp = ALU_OR;
          FN_SLT:  ALUOp = ALU_SLT;
          FN_SLTU: ALUOp = ALU_SLTU;
          default: ALUOp = ALU_NOP;
        endcase
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = (Op != OP_ORI); // ori takes a zero-extended immediate
        case (Op)
          OP_ADDI: ALUOp = ALU_ADD;
          OP_ORI:  ALUOp = ALU_OR;
          OP_SLTI: ALUOp = ALU_SLT;
          default: ALUOp = ALU_NOP;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = (Op == OP_RTYPE);
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        PCSrc   = 2'b01;          // target computed in DECODE, held in ALUOut
        if (Op == OP_BEQ)      PCWrite = Zero;
        else if (Op == OP_BNE) PCWrite = ~Zero;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH; // unused codes 11-15 recover silently
    endcase

    if (retire) instret_d = instret_q + INSTRET_W'(1);

    // Reset abandons the current instruction: suppress every architectural
    // write and the illegal pulse in the reset cycle itself.
    if (rst) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule
